// File: rtl/guess_engine_pkg.sv
// Purpose : shared CM-bus protocol bytes and guess_engine state encoding.
// Latency : n/a (types, constants and helpers only).
// Backpressure: n/a.
package guess_engine_pkg;

   // CM bus protocol bytes
   localparam logic [7:0] CM_START = 8'h01;
   localparam logic [7:0] CM_BEGIN = 8'h02;
   localparam logic [7:0] CM_YES   = 8'h03;
   localparam logic [7:0] CM_NO    = 8'h04;
   localparam logic [7:0] CM_END   = 8'h05;

   // 3-bit encoding; code 3'd7 is unused and parks like IDLE.
   typedef enum logic [2:0] {
      ST_IDLE       = 3'd0,
      ST_SEND_BEGIN = 3'd1,
      ST_SEND_DATA  = 3'd2,
      ST_SEND_END   = 3'd3,
      ST_WAIT_REPLY = 3'd4,
      ST_DONE       = 3'd5,
      ST_ERROR      = 3'd6
   } state_e;

   // States in which the engine owns the bus.
   function automatic logic is_driving(input state_e s);
      return (s == ST_SEND_BEGIN) || (s == ST_SEND_DATA) || (s == ST_SEND_END);
   endfunction

   // Anything that is not resting or terminal counts as busy.
   function automatic logic is_busy(input state_e s);
      return !((s == ST_IDLE) || (s == ST_DONE) || (s == ST_ERROR));
   endfunction

endpackage

// File: rtl/guess_engine_tracker.sv
// Purpose : reply-latency counter plus slowest-NO tracker (max_latency / max_guess).
// Latency : all outputs registered; counter and max update one cycle after the strobe.
// Backpressure: none; strobes are single-cycle and always accepted.
// Ports   : lat_clr/lat_inc drive the counter, no_evt requests a compare-and-load of
//           the current latency against max_latency, cur_guess is stored on a load.
module guess_latency_tracker #(
   parameter int CNT_W = 16,
   parameter int GW    = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             lat_clr,
   input  logic             lat_inc,
   input  logic             no_evt,
   input  logic [GW-1:0]    cur_guess,
   output logic [CNT_W-1:0] latency,
   output logic [CNT_W-1:0] max_latency,
   output logic [GW-1:0]    max_guess
);

   logic [CNT_W-1:0] latency_q, latency_d;
   logic [CNT_W-1:0] max_latency_q, max_latency_d;
   logic [GW-1:0]    max_guess_q, max_guess_d;

   always_comb begin
      latency_d     = latency_q;
      max_latency_d = max_latency_q;
      max_guess_d   = max_guess_q;

      // Clear wins over increment; the counter sticks at all-ones.
      if (lat_clr) begin
         latency_d = '0;
      end else if (lat_inc && (latency_q != '1)) begin
         latency_d = latency_q + 1'b1;
      end

      // Strictly greater: an equal latency keeps the earlier guess.
      if (no_evt && (latency_q > max_latency_q)) begin
         max_latency_d = latency_q;
         max_guess_d   = cur_guess;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         latency_q     <= '0;
         max_latency_q <= '0;
         max_guess_q   <= '0;
      end else begin
         latency_q     <= latency_d;
         max_latency_q <= max_latency_d;
         max_guess_q   <= max_guess_d;
      end
   end

   assign latency     = latency_q;
   assign max_latency = max_latency_q;
   assign max_guess   = max_guess_q;

endmodule

// File: rtl/guess_engine.sv
// Purpose : drives framed multi-byte guesses onto the CM bus and waits for YES/NO with
//           timeout and bounded retry; tracks the slowest rejected guess.
// Latency : first frame byte appears the cycle after START is sampled; all outputs registered.
// Backpressure: none; the bus peer paces the engine only through YES/NO/timeout.
// Ports   : clk/rst (async, active-high); data_in/data_out/drive_en to cm_bus_if;
//           guess_out, max_latency, max_guess, done, error, busy are status for LED/debug.
module guess_engine
   import guess_engine_pkg::*;
#(
   parameter int GUESS_BYTES = 2,
   parameter int CNT_W       = 16,
   parameter int TIMEOUT     = 1000,
   parameter int MAX_RETRY   = 3
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [7:0]               data_in,
   output logic [7:0]               data_out,
   output logic                     drive_en,
   output logic [8*GUESS_BYTES-1:0] guess_out,
   output logic [CNT_W-1:0]         max_latency,
   output logic [8*GUESS_BYTES-1:0] max_guess,
   output logic                     done,
   output logic                     error,
   output logic                     busy
);

   localparam int GW      = 8 * GUESS_BYTES;
   localparam int RETRY_W = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);

   localparam logic [1:0]         LAST_IDX  = 2'(GUESS_BYTES - 1);
   localparam logic [CNT_W-1:0]   TO_LAST   = CNT_W'(TIMEOUT - 1);
   localparam logic [RETRY_W-1:0] RETRY_MAX = RETRY_W'(MAX_RETRY);

   state_e             state_q, state_d;
   logic [1:0]         idx_q, idx_d;
   logic [RETRY_W-1:0] retry_q, retry_d;
   logic [GW-1:0]      guess_q, guess_d;
   logic [7:0]         data_out_q, data_out_d;
   logic               drive_en_q, drive_en_d;
   logic               done_q, done_d;
   logic               error_q, error_d;
   logic               busy_q, busy_d;

   logic [CNT_W-1:0]   latency;
   logic               in_wait;
   logic               got_yes;
   logic               got_no;
   logic               no_evt;
   logic [GW-1:0]      guess_sh;

   // data_in is only acted on in IDLE and WAIT_REPLY, so our own echo is ignored.
   assign in_wait = (state_q == ST_WAIT_REPLY);
   assign got_yes = (data_in == CM_YES);
   assign got_no  = (data_in == CM_NO);
   assign no_evt  = in_wait && got_no;

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      retry_d = retry_q;
      guess_d = guess_q;

      case (state_q)
         ST_IDLE: begin
            if (data_in == CM_START) begin
               state_d = ST_SEND_BEGIN;
            end
         end
         ST_SEND_BEGIN: begin
            state_d = ST_SEND_DATA;
            idx_d   = '0;
         end
         ST_SEND_DATA: begin
            if (idx_q == LAST_IDX) begin
               state_d = ST_SEND_END;
            end else begin
               idx_d = idx_q + 2'd1;
            end
         end
         ST_SEND_END: begin
            state_d = ST_WAIT_REPLY;
         end
         ST_WAIT_REPLY: begin
            // A reply on the timeout cycle takes priority over the timeout.
            if (got_yes) begin
               state_d = ST_DONE;
            end else if (got_no) begin
               retry_d = '0;
               if (guess_q == '1) begin
                  state_d = ST_ERROR;
               end else begin
                  guess_d = guess_q + 1'b1;
                  state_d = ST_SEND_BEGIN;
               end
            end else if (latency == TO_LAST) begin
               if (retry_q == RETRY_MAX) begin
                  state_d = ST_ERROR;
               end else begin
                  retry_d = retry_q + 1'b1;
                  state_d = ST_SEND_BEGIN;
               end
            end
         end
         ST_DONE:  state_d = ST_DONE;
         ST_ERROR: state_d = ST_ERROR;
         default:  state_d = ST_IDLE;
      endcase

      // Outputs are decoded from the next state so they are registered yet
      // line up with the state they describe.
      guess_sh   = guess_d >> (8 * (GUESS_BYTES - 1 - int'(idx_d)));
      drive_en_d = is_driving(state_d);
      busy_d     = is_busy(state_d);
      done_d     = (state_d == ST_DONE);
      error_d    = (state_d == ST_ERROR);
      case (state_d)
         ST_SEND_BEGIN: data_out_d = CM_BEGIN;
         ST_SEND_DATA:  data_out_d = guess_sh[7:0];
         ST_SEND_END:   data_out_d = CM_END;
         default:       data_out_d = 8'h00;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= ST_IDLE;
         idx_q      <= '0;
         retry_q    <= '0;
         guess_q    <= '0;
         data_out_q <= 8'h00;
         drive_en_q <= 1'b0;
         done_q     <= 1'b0;
         error_q    <= 1'b0;
         busy_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         idx_q      <= idx_d;
         retry_q    <= retry_d;
         guess_q    <= guess_d;
         data_out_q <= data_out_d;
         drive_en_q <= drive_en_d;
         done_q     <= done_d;
         error_q    <= error_d;
         busy_q     <= busy_d;
      end
   end

   // Latency restarts as the END byte goes out, so it counts whole WAIT_REPLY cycles.
   guess_latency_tracker #(
      .CNT_W (CNT_W),
      .GW    (GW)
   ) u_tracker (
      .clk         (clk),
      .rst         (rst),
      .lat_clr     (state_q == ST_SEND_END),
      .lat_inc     (in_wait),
      .no_evt      (no_evt),
      .cur_guess   (guess_q),
      .latency     (latency),
      .max_latency (max_latency),
      .max_guess   (max_guess)
   );

   assign data_out  = data_out_q;
   assign drive_en  = drive_en_q;
   assign guess_out = guess_q;
   assign done      = done_q;
   assign error     = error_q;
   assign busy      = busy_q;

endmodule
